// File: rtl/us_sched_pkg.sv
// ---------------------------------------------------------------------------
// us_sched_pkg
// Shared types and constants for the ultrasonic round-robin scheduler:
//   state_t          - scheduler FSM states
//   TIMEOUT_CODE     - distance value stored when a sensor never answers
//   DEF_*            - default channel count and timing (in tick_10us pulses)
//   sat_inc16        - 16-bit saturating increment used by the tick timer
// ---------------------------------------------------------------------------
package us_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_CODE = 16'hFFFF;

  localparam int DEF_NUM_ULTRASONICS = 9;
  localparam int DEF_TIMEOUT_TICKS   = 4000;  // 40 ms at 10 us per tick
  localparam int DEF_GUARD_TICKS     = 6000;  // 60 ms anti-crosstalk gap

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : (value + 16'd1);
  endfunction

endpackage

// File: rtl/us_tick_timer.sv
// ---------------------------------------------------------------------------
// us_tick_timer
// 16-bit saturating counter of tick_10us pulses with a compare against a
// runtime limit. One instance is shared by the WAIT and GUARD phases.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - synchronous restart to zero (wins over tick)
//   tick        - count enable, one pulse per 10 us
//   limit       - number of ticks after which expired asserts
//   expired     - combinational: the count reaches limit on this clock
// ---------------------------------------------------------------------------
module us_tick_timer
  import us_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        tick,
  input  logic [15:0] limit,
  output logic        expired
);

  logic [15:0] count_r;
  logic [15:0] count_next_s;

  // Value the counter takes on this edge when not cleared.
  always_comb begin
    count_next_s = count_r;
    if (tick) begin
      count_next_s = sat_inc16(count_r);
    end else begin
      count_next_s = count_r;
    end
  end

  // Looking at the post-increment value lets the caller act in the same
  // clock as the tick that completes the interval; independent of clear so
  // the FSM can use expired to decide whether to clear.
  assign expired = (count_next_s >= limit);

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 16'd0;
    end else if (clear) begin
      count_r <= 16'd0;
    end else begin
      count_r <= count_next_s;
    end
  end

endmodule

// File: rtl/us_scheduler.sv
// ---------------------------------------------------------------------------
// us_scheduler
// Round-robin scheduler for NUM_ULTRASONICS ranging units. Each channel is
// triggered with a one-clock measure pulse, its result (or FFFF on timeout)
// is latched into a distance table, then a guard interval of quiet time
// passes before the next channel is triggered.
// Ports:
//   clk, rst_n  - 50 MHz clock, asynchronous active-low reset
//   tick_10us   - one-clock enable every 10 us, base of all timing
//   enable      - run frames continuously; low stops after current channel
//   valid_in    - per-sensor valid level (rising edge = new result)
//   ticks_in    - per-sensor distance, channel i at [16i+15:16i]
//   measure     - one-hot trigger pulse to the serviced sensor
//   dists       - latched distance table, same packing as ticks_in
//   fresh       - bit i set = dists entry i written in this frame
//   frame_done  - one-clock pulse when a frame wraps
//   busy        - scheduler not idle
//   cur_ch      - channel being serviced
// ---------------------------------------------------------------------------
module us_scheduler
  import us_sched_pkg::*;
#(
  parameter int NUM_ULTRASONICS = DEF_NUM_ULTRASONICS,
  parameter int TIMEOUT_TICKS   = DEF_TIMEOUT_TICKS,
  parameter int GUARD_TICKS     = DEF_GUARD_TICKS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick_10us,
  input  logic                         enable,
  input  logic [NUM_ULTRASONICS-1:0]   valid_in,
  input  logic [16*NUM_ULTRASONICS-1:0] ticks_in,
  output logic [NUM_ULTRASONICS-1:0]   measure,
  output logic [16*NUM_ULTRASONICS-1:0] dists,
  output logic [NUM_ULTRASONICS-1:0]   fresh,
  output logic                         frame_done,
  output logic                         busy,
  output logic [3:0]                   cur_ch
);

  localparam logic [3:0]  LAST_CH       = 4'(NUM_ULTRASONICS - 1);
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_TICKS);
  localparam logic [15:0] GUARD_LIMIT   = 16'(GUARD_TICKS);

  state_t                        state_r, state_next_s;
  logic [3:0]                    cur_ch_r, cur_ch_next_s;
  logic [NUM_ULTRASONICS-1:0]    valid_q_r;
  logic                          first_wait_r;
  logic [NUM_ULTRASONICS-1:0]    measure_r, measure_next_s;
  logic [16*NUM_ULTRASONICS-1:0] dists_r, dists_next_s;
  logic [NUM_ULTRASONICS-1:0]    fresh_r, fresh_next_s;
  logic                          frame_done_r, frame_done_next_s;
  logic                          busy_r;

  logic                          valid_sel_s, valid_q_sel_s;
  logic [15:0]                   ticks_sel_s;
  logic                          edge_s;
  logic                          store_s;
  logic [15:0]                   store_val_s;
  logic                          fresh_clear_s;
  logic                          timer_clear_s;
  logic                          timer_expired_s;
  logic [15:0]                   timer_limit_s;

  // Same counter serves both phases; only the limit differs.
  assign timer_limit_s = (state_r == ST_GUARD) ? GUARD_LIMIT : TIMEOUT_LIMIT;

  us_tick_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear_s),
    .tick    (tick_10us),
    .limit   (timer_limit_s),
    .expired (timer_expired_s)
  );

  // Select the serviced channel's valid, delayed valid and distance (AND-OR mux).
  always_comb begin
    valid_sel_s   = 1'b0;
    valid_q_sel_s = 1'b0;
    ticks_sel_s   = 16'd0;
    for (int i = 0; i < NUM_ULTRASONICS; i++) begin
      valid_sel_s   = valid_sel_s   | (valid_in[i]  & (cur_ch_r == 4'(i)));
      valid_q_sel_s = valid_q_sel_s | (valid_q_r[i] & (cur_ch_r == 4'(i)));
      ticks_sel_s   = ticks_sel_s   | (ticks_in[16*i +: 16] & {16{cur_ch_r == 4'(i)}});
    end
  end

  // A stale valid from the previous measurement may still be settling right
  // after the trigger, so edges in the first WAIT clock are not trusted.
  assign edge_s = valid_sel_s & ~valid_q_sel_s & (state_r == ST_WAIT) & ~first_wait_r;

  // Next-state and control decode.
  always_comb begin
    state_next_s      = state_r;
    cur_ch_next_s     = cur_ch_r;
    timer_clear_s     = 1'b0;
    store_s           = 1'b0;
    store_val_s       = TIMEOUT_CODE;
    fresh_clear_s     = 1'b0;
    frame_done_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_next_s  = ST_ARM;
          cur_ch_next_s = 4'd0;
          fresh_clear_s = 1'b1;
        end else begin
          state_next_s  = ST_IDLE;
        end
      end
      ST_ARM: begin
        timer_clear_s = 1'b1;
        state_next_s  = ST_WAIT;
      end
      ST_WAIT: begin
        // Edge is checked first so a result arriving with the final tick wins.
        if (edge_s) begin
          store_s       = 1'b1;
          store_val_s   = ticks_sel_s;
          timer_clear_s = 1'b1;
          state_next_s  = ST_GUARD;
        end else if (timer_expired_s) begin
          store_s       = 1'b1;
          store_val_s   = TIMEOUT_CODE;
          timer_clear_s = 1'b1;
          state_next_s  = ST_GUARD;
        end else begin
          state_next_s  = ST_WAIT;
        end
      end
      ST_GUARD: begin
        if (timer_expired_s) begin
          state_next_s = enable ? ST_ARM : ST_IDLE;
          if (cur_ch_r == LAST_CH) begin
            cur_ch_next_s     = 4'd0;
            frame_done_next_s = 1'b1;
            fresh_clear_s     = enable;
          end else begin
            cur_ch_next_s     = cur_ch_r + 4'd1;
          end
        end else begin
          state_next_s = ST_GUARD;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    dists_next_s   = dists_r;
    fresh_next_s   = fresh_r;
    measure_next_s = '0;
    for (int i = 0; i < NUM_ULTRASONICS; i++) begin
      dists_next_s[16*i +: 16] = (store_s && (cur_ch_r == 4'(i))) ? store_val_s : dists_r[16*i +: 16];
      fresh_next_s[i] = (store_s && (cur_ch_r == 4'(i))) ? 1'b1 : (fresh_r[i] & ~fresh_clear_s);
      // Registered trigger lines up exactly with the ARM state.
      measure_next_s[i] = (state_next_s == ST_ARM) && (cur_ch_next_s == 4'(i));
    end
  end

  // FSM state and channel pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cur_ch_r <= 4'd0;
    end else begin
      state_r  <= state_next_s;
      cur_ch_r <= cur_ch_next_s;
    end
  end

  // Edge-detect history, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q_r    <= '0;
      first_wait_r <= 1'b0;
      measure_r    <= '0;
      dists_r      <= '0;
      fresh_r      <= '0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      valid_q_r    <= valid_in;
      first_wait_r <= (state_r == ST_ARM);
      measure_r    <= measure_next_s;
      dists_r      <= dists_next_s;
      fresh_r      <= fresh_next_s;
      frame_done_r <= frame_done_next_s;
      busy_r       <= (state_next_s != ST_IDLE);
    end
  end

  assign measure    = measure_r;
  assign dists      = dists_r;
  assign fresh      = fresh_r;
  assign frame_done = frame_done_r;
  assign busy       = busy_r;
  assign cur_ch     = cur_ch_r;

endmodule

// File: tb/tb_us_scheduler.sv
module tb_us_scheduler;

  localparam int N  = 3;
  localparam int TO = 20;
  localparam int GU = 10;
  localparam int TD = 4;   // clocks per tick_10us pulse

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tick_10us;
  logic              enable;
  logic [N-1:0]      valid_in;
  logic [16*N-1:0]   ticks_in;
  logic [N-1:0]      measure;
  logic [16*N-1:0]   dists;
  logic [N-1:0]      fresh;
  logic              frame_done;
  logic              busy;
  logic [3:0]        cur_ch;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ticks_total = 0;
  int store_ticks = 0;
  bit guard_chk = 1'b0;
  int fd_total = 0;
  int fd_expect = 0;
  logic [15:0] exp_d [N];

  us_scheduler #(.NUM_ULTRASONICS(N), .TIMEOUT_TICKS(TO), .GUARD_TICKS(GU)) dut (
    .clk(clk), .rst_n(rst_n), .tick_10us(tick_10us), .enable(enable),
    .valid_in(valid_in), .ticks_in(ticks_in), .measure(measure), .dists(dists),
    .fresh(fresh), .frame_done(frame_done), .busy(busy), .cur_ch(cur_ch)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16*N-1:0] model_table();
    logic [16*N-1:0] p;
    for (int i = 0; i < N; i++) p[16*i +: 16] = exp_d[i];
    return p;
  endfunction

  function automatic int rand_delay();
    return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 19));
  endfunction

  // one clock: drive tick before the rising edge, return at the falling edge
  task automatic step();
    tick_10us = ((cyc % TD) == 0);
    @(posedge clk);
    if (tick_10us) ticks_total++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_measure(input int ch);
    int n = 0;
    while (measure === '0 && n < 300) begin
      step();
      n++;
    end
    chk("measure_order", 64'(measure), 64'(1 << ch));
    chk("cur_ch", 64'(cur_ch), 64'(ch));
    if (guard_chk) chk("guard_ticks", 64'(ticks_total - store_ticks), 64'(GU));
  endtask

  task automatic frame_start(input bit wrapped);
    wait_measure(0);
    chk("frame_done", 64'(frame_done), 64'(wrapped));
    chk("fresh_cleared", 64'(fresh), 64'(0));
    chk("dists_table", 64'(dists), 64'(model_table()));
    if (wrapped) fd_expect++;
  endtask

  // d = 0: sensor never answers; otherwise valid rises together with the d-th tick
  task automatic service(input int ch, input int d, input logic [15:0] val, input bit drop_en);
    int cnt = 0;
    bit raised = 1'b0;
    bit nt;
    logic [15:0] expv;
    valid_in[ch] = 1'b0;
    step();
    chk("measure_width", 64'(measure), 64'(0));
    if (drop_en) enable = 1'b0;
    for (int k = 0; k < 400; k++) begin
      nt = ((cyc % TD) == 0);
      if (d != 0 && !raised && (cnt + int'(nt)) == d) begin
        ticks_in[16*ch +: 16] = val;
        valid_in[ch] = 1'b1;
        raised = 1'b1;
      end
      step();
      if (nt) cnt++;
      if (fresh[ch] === 1'b1 || cnt >= TO) break;
    end
    expv = (d == 0) ? 16'hFFFF : val;
    chk("store_tick", 64'(cnt), 64'((d == 0) ? TO : d));
    chk("fresh_bit", 64'(fresh[ch]), 64'(1));
    chk("dist_value", 64'(dists[16*ch +: 16]), 64'(expv));
    exp_d[ch] = expv;
    store_ticks = ticks_total;
    guard_chk = 1'b1;
  endtask

  task automatic run_frame(input int d0, input int d1, input int d2,
                           input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2);
    service(0, d0, v0, 1'b0);
    wait_measure(1);
    service(1, d1, v1, 1'b0);
    wait_measure(2);
    service(2, d2, v2, 1'b0);
    frame_start(1'b1);
  endtask

  // continuous trigger-line checks
  initial begin
    bit have_prev = 1'b0;
    int prev_ticks = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_prev = 1'b0;
      end else begin
        if (measure !== '0) begin
          chk("measure_onehot", 64'($onehot(measure)), 64'(1));
          if (have_prev) chk("measure_spacing", 64'((ticks_total - prev_ticks) >= GU), 64'(1));
          have_prev = 1'b1;
          prev_ticks = ticks_total;
        end
        if (frame_done === 1'b1) fd_total++;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; tick_10us = 1'b0;
    valid_in = '0; ticks_in = '0;
    for (int i = 0; i < N; i++) exp_d[i] = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_measure", 64'(measure), 64'(0));
    chk("rst_dists", 64'(dists), 64'(0));
    chk("rst_fresh", 64'(fresh), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_cur_ch", 64'(cur_ch), 64'(0));
    rst_n = 1'b1;
    repeat (4) step();
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_measure", 64'(measure), 64'(0));

    enable = 1'b1;
    frame_start(1'b0);
    chk("busy_run", 64'(busy), 64'(1));
    run_frame(5, 5, 5, 16'd100, 16'd200, 16'd300);
    chk("frame1_table", 64'(dists), 64'({16'd300, 16'd200, 16'd100}));
    run_frame(int'($urandom_range(2, 19)), 0, int'($urandom_range(2, 19)),
              16'($urandom_range(0, 65534)), 16'd7, 16'($urandom_range(0, 65534)));
    run_frame(20, int'($urandom_range(2, 19)), 20,
              16'($urandom_range(0, 65534)), 16'($urandom_range(0, 65534)), 16'($urandom_range(0, 65534)));
    for (int f = 0; f < 3; f++) begin
      run_frame(rand_delay(), rand_delay(), rand_delay(),
                16'($urandom_range(0, 65534)), 16'($urandom_range(0, 65534)), 16'($urandom_range(0, 65534)));
    end

    // enable dropped while channel 1 waits for its echo
    service(0, rand_delay(), 16'($urandom_range(0, 65534)), 1'b0);
    wait_measure(1);
    service(1, 8, 16'h1234, 1'b1);
    begin
      int n = 0;
      while (busy === 1'b1 && n < 300) begin
        step();
        n++;
      end
    end
    chk("drop_busy", 64'(busy), 64'(0));
    chk("drop_guard", 64'(ticks_total - store_ticks), 64'(GU));
    chk("drop_cur_ch", 64'(cur_ch), 64'(2));
    chk("drop_fresh", 64'(fresh), 64'(3'b011));
    chk("drop_table", 64'(dists), 64'(model_table()));
    for (int k = 0; k < 40; k++) begin
      step();
      chk("drop_no_measure", 64'(measure), 64'(0));
    end
    chk("hold_table", 64'(dists), 64'(model_table()));
    guard_chk = 1'b0;

    // restart from idle, then reset in the middle of channel 1's wait
    enable = 1'b1;
    frame_start(1'b0);
    service(0, rand_delay(), 16'($urandom_range(0, 65534)), 1'b0);
    wait_measure(1);
    valid_in[1] = 1'b0;
    repeat (6) step();
    #3 rst_n = 1'b0;
    #1;
    chk("abort_measure", 64'(measure), 64'(0));
    chk("abort_dists", 64'(dists), 64'(0));
    chk("abort_fresh", 64'(fresh), 64'(0));
    chk("abort_frame_done", 64'(frame_done), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_cur_ch", 64'(cur_ch), 64'(0));
    for (int i = 0; i < N; i++) exp_d[i] = 16'd0;
    guard_chk = 1'b0;
    @(negedge clk);
    repeat (3) step();
    rst_n = 1'b1;
    frame_start(1'b0);
    run_frame(rand_delay(), rand_delay(), rand_delay(),
              16'($urandom_range(0, 65534)), 16'($urandom_range(0, 65534)), 16'($urandom_range(0, 65534)));
    step();
    chk("frame_done_count", 64'(fd_total), 64'(fd_expect));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
